round_judge: RTL and testbench
==============================

Name: round_judge

Overview:
- Round-control FSM for the two-player light-cycle game; sits directly upstream of the score counter.
- Turns raw per-player crash levels from the collision detector into clean round results:
  - a one-cycle win strobe with stable player-won qualifiers, which feeds the score counter's enable/clock pair;
  - a clear pulse for a new match.
- Also sequences the pre-round countdown, the result hold and match end, and exposes round_active to gate cycle movement.

Parameters:
- COUNTDOWN_TICKS, 3: frame ticks of countdown before each round (1..15).
- SETTLE_CYCLES, 4: clk cycles after the first crash during which a second crash makes the round a draw (>=1).
- RESULT_TICKS, 60: frame ticks the result is held before the next countdown (>=1).
- WIN_TARGET, 5: round wins needed to end the match (1..2^TALLY_W-1).
- TALLY_W, 4: width of the internal win tallies.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  start/new-match request, level; rising edge detected internally
- frame_tick  in  1  one-cycle pulse per video frame
- p1_crash  in  1  player 1 collision, level, synchronous to clk
- p2_crash  in  1  player 2 collision, level, synchronous to clk
- round_active  out  1  high while cycles may move (PLAY only)
- countdown  out  4  remaining countdown ticks; 0 outside COUNTDOWN
- p1_won  out  1  player 1 won last round / match
- p2_won  out  1  player 2 won last round / match
- draw  out  1  last round was a draw
- win_strobe  out  1  one-cycle pulse, high only for a decided (non-draw) round
- score_clear_b  out  1  active-low score clear; low for exactly one cycle at new match
- p1_tally  out  TALLY_W  player 1 round wins this match
- p2_tally  out  TALLY_W  player 2 round wins this match
- match_over  out  1  high in MATCH_OVER

Behaviour:
- Reset (asynchronous, immediate):
  - state IDLE;
  - all outputs 0 except score_clear_b=1;
  - tallies 0; start edge register cleared.
  - An in-flight strobe is dropped; no partial strobe follows reset release.
- All outputs are registered. start_edge = start & ~start_q.
- States and transitions:
  - IDLE: start_edge -> COUNTDOWN.
    - Load count=COUNTDOWN_TICKS; tallies <=0; score_clear_b=0 for that one cycle.
  - COUNTDOWN: countdown=count.
    - Each frame_tick decrements count.
    - frame_tick with count==1 -> PLAY.
    - Crash inputs and start are ignored.
  - PLAY: round_active=1.
    - p1_crash & p2_crash in the same cycle -> RESULT, draw.
    - Exactly one crash -> SETTLE.
      - Record the first crasher; settle counter=SETTLE_CYCLES.
  - SETTLE: round_active=0. Settle counter decrements every clk.
    - The other player's crash while counter>0 -> RESULT, draw.
    - Counter reaches 0 with no second crash -> RESULT; the winner is the non-crasher.
    - A re-assertion by the first crasher is ignored.
  - RESULT:
    - On the entry cycle, p1_won/p2_won/draw are registered and held for the whole state.
    - Exactly one cycle after entry, if not a draw: win_strobe=1 for one cycle, and the winner's tally increments in that same cycle (saturating at WIN_TARGET).
    - The qualifiers are therefore stable at least one cycle before and during the strobe.
    - Draw: no strobe, tallies unchanged.
    - Count RESULT_TICKS frame_ticks, then:
      - either tally==WIN_TARGET -> MATCH_OVER;
      - else -> COUNTDOWN, reload count, clear p1_won/p2_won/draw, no score clear.
  - MATCH_OVER: match_over=1.
    - p1_won/p2_won indicate the match winner; tallies are held.
    - start_edge -> COUNTDOWN with the same clear actions as IDLE.
- start held high never retriggers; start_edge is ignored outside IDLE and MATCH_OVER.
- frame_tick is ignored in PLAY/SETTLE. A crash and a frame_tick in the same cycle are independent.
- p1_won, p2_won and draw are mutually exclusive; at most one is high.

Test Plan:
- Reset, start pulse, frame_tick every 10 clk, COUNTDOWN_TICKS=3 -> score_clear_b low 1 cycle; countdown 3,2,1,0; round_active rises on the cycle after the 3rd tick.
- PLAY, p2_crash at cycle t, no p1_crash -> SETTLE; at t+1+4 RESULT with p1_won=1; win_strobe one cycle later; p1_tally=1, p2_tally=0.
- PLAY, p1_crash at t, p2_crash at t+2 -> draw=1, no win_strobe, tallies unchanged; same-cycle crashes give an identical outcome.
- WIN_TARGET=2, p1 wins two rounds -> MATCH_OVER, match_over=1, p1_won=1, p1_tally=2; start held high gives nothing, a new edge gives score_clear_b pulse and tallies 0.
- Reset asserted in the cycle between RESULT entry and strobe -> win_strobe never rises, IDLE, all outputs at reset values.
- Crashes and start toggled during COUNTDOWN -> ignored; countdown continues, no state change.

Source files
------------

// File: rtl/round_judge.sv
// Round-control FSM for the two-player light-cycle game: countdown, crash
// settling, result hold with a one-cycle win strobe, and match end.
module round_judge #(
   parameter int COUNTDOWN_TICKS = 3,
   parameter int SETTLE_CYCLES   = 4,
   parameter int RESULT_TICKS    = 60,
   parameter int WIN_TARGET      = 5,
   parameter int TALLY_W         = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               frame_tick,
   input  logic               p1_crash,
   input  logic               p2_crash,
   output logic               round_active,
   output logic [3:0]         countdown,
   output logic               p1_won,
   output logic               p2_won,
   output logic               draw,
   output logic               win_strobe,
   output logic               score_clear_b,
   output logic [TALLY_W-1:0] p1_tally,
   output logic [TALLY_W-1:0] p2_tally,
   output logic               match_over
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1) + 1;
   localparam int RW = $clog2(RESULT_TICKS + 1) + 1;

   typedef enum logic [2:0] {IDLE, COUNTDOWN, PLAY, SETTLE, RESULT, MATCH_OVER} state_t;

   state_t        state;
   logic          start_q;
   logic          first_p1;
   logic          strobe_pend;
   logic [SW-1:0] settle_cnt;
   logic [RW-1:0] res_cnt;
   logic [RW-1:0] res_cnt_nx;
   logic          start_edge;
   logic          target_hit;
   logic          second_crash;

   assign start_edge   = start & ~start_q;
   assign res_cnt_nx   = res_cnt + RW'(frame_tick);
   assign target_hit   = (p1_tally == TALLY_W'(WIN_TARGET)) || (p2_tally == TALLY_W'(WIN_TARGET));
   assign second_crash = first_p1 ? p2_crash : p1_crash;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         start_q       <= 1'b0;
         first_p1      <= 1'b0;
         strobe_pend   <= 1'b0;
         settle_cnt    <= '0;
         res_cnt       <= '0;
         round_active  <= 1'b0;
         countdown     <= 4'd0;
         p1_won        <= 1'b0;
         p2_won        <= 1'b0;
         draw          <= 1'b0;
         win_strobe    <= 1'b0;
         score_clear_b <= 1'b1;
         p1_tally      <= '0;
         p2_tally      <= '0;
         match_over    <= 1'b0;
      end else begin
         start_q       <= start;
         score_clear_b <= 1'b1;
         win_strobe    <= 1'b0;
         case (state)
            IDLE, MATCH_OVER: begin
               if (start_edge) begin
                  state         <= COUNTDOWN;
                  countdown     <= 4'(COUNTDOWN_TICKS);
                  p1_tally      <= '0;
                  p2_tally      <= '0;
                  score_clear_b <= 1'b0;
                  match_over    <= 1'b0;
                  p1_won        <= 1'b0;
                  p2_won        <= 1'b0;
                  draw          <= 1'b0;
               end
            end
            COUNTDOWN: begin
               if (frame_tick) begin
                  if (countdown == 4'd1) begin
                     state        <= PLAY;
                     countdown    <= 4'd0;
                     round_active <= 1'b1;
                  end else begin
                     countdown <= countdown - 4'd1;
                  end
               end
            end
            PLAY: begin
               if (p1_crash && p2_crash) begin
                  state        <= RESULT;
                  draw         <= 1'b1;
                  strobe_pend  <= 1'b0;
                  res_cnt      <= '0;
                  round_active <= 1'b0;
               end else if (p1_crash || p2_crash) begin
                  state        <= SETTLE;
                  first_p1     <= p1_crash;
                  settle_cnt   <= SW'(SETTLE_CYCLES);
                  round_active <= 1'b0;
               end
            end
            SETTLE: begin
               res_cnt <= '0;
               if (second_crash) begin
                  state       <= RESULT;
                  draw        <= 1'b1;
                  strobe_pend <= 1'b0;
               end else if (settle_cnt == SW'(1)) begin
                  state       <= RESULT;
                  p1_won      <= ~first_p1;
                  p2_won      <= first_p1;
                  strobe_pend <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt - SW'(1);
               end
            end
            RESULT: begin
               if (frame_tick) res_cnt <= res_cnt_nx;
               // Exit waits until the strobe has updated the tallies.
               if (strobe_pend) begin
                  strobe_pend <= 1'b0;
                  win_strobe  <= 1'b1;
                  if (p1_won && p1_tally < TALLY_W'(WIN_TARGET)) p1_tally <= p1_tally + TALLY_W'(1);
                  if (p2_won && p2_tally < TALLY_W'(WIN_TARGET)) p2_tally <= p2_tally + TALLY_W'(1);
               end else if (res_cnt_nx >= RW'(RESULT_TICKS)) begin
                  if (target_hit) begin
                     state      <= MATCH_OVER;
                     match_over <= 1'b1;
                  end else begin
                     state     <= COUNTDOWN;
                     countdown <= 4'(COUNTDOWN_TICKS);
                     p1_won    <= 1'b0;
                     p2_won    <= 1'b0;
                     draw      <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_round_judge.sv
// Directed bench for round_judge with a queue of expected round outcomes.
module tb_round_judge;

   logic       clk = 1'b0;
   logic       reset, start, frame_tick, p1_crash, p2_crash;
   logic       round_active, p1_won, p2_won, draw, win_strobe, score_clear_b, match_over;
   logic [3:0] countdown, p1_tally, p2_tally;
   logic [18:0] outvec;

   int total = 0;
   int bad = 0;
   int n_strobe = 0;
   int e1 = 0;
   int e2 = 0;
   logic [2:0] exp_q[$];

   round_judge #(.COUNTDOWN_TICKS(3), .SETTLE_CYCLES(4), .RESULT_TICKS(2),
                 .WIN_TARGET(2), .TALLY_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
      .p1_crash(p1_crash), .p2_crash(p2_crash), .round_active(round_active),
      .countdown(countdown), .p1_won(p1_won), .p2_won(p2_won), .draw(draw),
      .win_strobe(win_strobe), .score_clear_b(score_clear_b),
      .p1_tally(p1_tally), .p2_tally(p2_tally), .match_over(match_over)
   );

   assign outvec = {round_active, countdown, p1_won, p2_won, draw, win_strobe,
                    score_clear_b, p1_tally, p2_tally, match_over};

   always #5 clk = ~clk;

   always @(negedge clk) if (win_strobe === 1'b1) n_strobe++;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      repeat (9) cyc();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic to_play();
      repeat (3) tick();
      check("play_active", round_active, 1);
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!(p1_won | p2_won | draw) && lat < 50) begin
         cyc();
         lat++;
      end
   endtask

   // Pops the expected outcome, checks latency, strobe and tallies, then
   // runs out the result hold.
   task automatic resolve(input string tag, input int exp_lat);
      int lat;
      logic [2:0] e;
      wait_result(lat);
      check({tag, "_lat"}, lat, exp_lat);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b111;
      check({tag, "_quals"}, {p1_won, p2_won, draw}, e);
      check({tag, "_no_early_strobe"}, win_strobe, 0);
      cyc();
      check({tag, "_strobe"}, win_strobe, {31'd0, ~e[0]});
      if (e[2] && e1 < 2) e1++;
      if (e[1] && e2 < 2) e2++;
      check({tag, "_tallies"}, {p1_tally, p2_tally}, {e1[3:0], e2[3:0]});
      cyc();
      check({tag, "_strobe_off"}, win_strobe, 0);
      tick();
      tick();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; frame_tick = 1'b0; p1_crash = 1'b0; p2_crash = 1'b0;
      repeat (2) cyc();
      check("reset_outputs", outvec, 32'h200);
      reset = 1'b0;
      cyc();

      start = 1'b1;
      cyc();
      check("clear_low", score_clear_b, 0);
      check("cd_load", countdown, 3);
      start = 1'b0;
      cyc();
      check("clear_high", score_clear_b, 1);
      tick();
      check("cd2", countdown, 2);
      tick();
      check("cd1", countdown, 1);
      check("not_active_yet", round_active, 0);
      tick();
      check("cd0", countdown, 0);
      check("active_rise", round_active, 1);

      // Round 1: p2 crashes alone, p1 wins after the settle window
      p2_crash = 1'b1;
      exp_q.push_back(3'b100);
      cyc();
      p2_crash = 1'b0;
      check("settle_inactive", round_active, 0);
      resolve("r1_p1win", 4);
      check("r1_next_cd", countdown, 3);
      check("r1_quals_clr", {p1_won, p2_won, draw}, 0);

      // Noise during countdown is ignored
      p1_crash = 1'b1; p2_crash = 1'b1; start = 1'b1;
      cyc();
      check("noise_cd", countdown, 3);
      check("noise_ra", round_active, 0);
      start = 1'b0;
      cyc();
      start = 1'b1;
      cyc();
      check("noise_clear", score_clear_b, 1);
      check("noise_tally", {p1_tally, p2_tally}, 8'h10);
      p1_crash = 1'b0; p2_crash = 1'b0; start = 1'b0;
      to_play();

      // Round 2: p1 at t, p2 at t+2 -> draw
      p1_crash = 1'b1;
      exp_q.push_back(3'b001);
      cyc();
      p1_crash = 1'b0;
      cyc();
      p2_crash = 1'b1;
      cyc();
      p2_crash = 1'b0;
      resolve("r2_draw_seq", 0);
      to_play();

      // Round 3: simultaneous crashes -> draw
      p1_crash = 1'b1; p2_crash = 1'b1;
      exp_q.push_back(3'b001);
      cyc();
      p1_crash = 1'b0; p2_crash = 1'b0;
      resolve("r3_draw_same", 0);
      to_play();

      // Round 4: p1 crashes alone, p2 wins
      p1_crash = 1'b1;
      exp_q.push_back(3'b010);
      cyc();
      p1_crash = 1'b0;
      resolve("r4_p2win", 4);
      to_play();

      // Round 5: p1 reaches target; start goes high before match end
      p2_crash = 1'b1;
      exp_q.push_back(3'b100);
      cyc();
      p2_crash = 1'b0;
      start = 1'b1;
      resolve("r5_p1match", 4);
      check("mo_flag", match_over, 1);
      check("mo_winner", {p1_won, p2_won, draw}, 3'b100);
      check("mo_tally", p1_tally, 2);
      repeat (5) cyc();
      check("mo_held_start", match_over, 1);
      check("mo_held_clear", score_clear_b, 1);
      start = 1'b0;
      cyc();
      start = 1'b1;
      cyc();
      e1 = 0; e2 = 0;
      check("new_clear_low", score_clear_b, 0);
      check("new_tallies", {p1_tally, p2_tally}, 0);
      check("new_mo", match_over, 0);
      check("new_cd", countdown, 3);
      start = 1'b0;
      cyc();
      check("new_clear_high", score_clear_b, 1);
      check("strobe_count", n_strobe, 3);

      // Reset between RESULT entry and strobe drops the strobe
      to_play();
      p2_crash = 1'b1;
      cyc();
      p2_crash = 1'b0;
      begin
         int lat;
         wait_result(lat);
         check("rst_result_lat", lat, 4);
      end
      check("rst_pre_p1won", p1_won, 1);
      reset = 1'b1;
      #1;
      check("rst_async", outvec, 32'h200);
      cyc();
      reset = 1'b0;
      repeat (5) cyc();
      check("rst_no_strobe", n_strobe, 3);
      check("rst_idle_outputs", outvec, 32'h200);
      check("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
